// File: rtl/ahb_sram_slave_pkg.sv
// Shared AHB-Lite definitions for the SRAM responder: transfer, size, response and FSM state encodings.
package ahb_sram_slave_pkg;

    localparam int DATAWIDTH = 32;

    typedef enum logic {
        OKAY  = 1'b0,
        ERROR = 1'b1
    } Response_t;

    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_BUSY   = 2'b01,
        TR_NONSEQ = 2'b10,
        TR_SEQ    = 2'b11
    } Trans_t;

    typedef enum logic [2:0] {
        BYTE = 3'd0,
        HALF = 3'd1,
        WORD = 3'd2
    } Size_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } SlvState_t;

endpackage

// File: rtl/ahb_sram_slave_byte_strobe.sv
// Little-endian byte-lane enables for a 32-bit bus from transfer size and low address bits.
module ahb_byte_strobe
    import ahb_sram_slave_pkg::*;
(
    input  logic [2:0] size,
    input  logic [1:0] addr_lo,
    output logic [3:0] strobe
);

    always_comb begin
        strobe = 4'b0000;
        case (size)
            BYTE:    strobe = 4'b0001 << addr_lo;
            HALF:    strobe = addr_lo[1] ? 4'b1100 : 4'b0011;
            WORD:    strobe = 4'b1111;
            default: strobe = 4'b0000;
        endcase
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite word-addressed SRAM slave with programmable wait states and two-cycle ERROR response.
module ahb_sram_slave
    import ahb_sram_slave_pkg::*;
#(
    parameter int ADDRWIDTH   = 32,
    parameter int DATAWIDTH   = 32,
    parameter int MEM_DEPTH   = 256,
    parameter int WAIT_STATES = 0
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    input  logic                 HSEL,
    input  logic [ADDRWIDTH-1:0] HADDR,
    input  logic                 HWRITE,
    input  logic [2:0]           HSIZE,
    input  logic [1:0]           HTRANS,
    input  logic [DATAWIDTH-1:0] HWDATA,
    input  logic                 HREADY,
    output logic [DATAWIDTH-1:0] HRDATA,
    output logic                 HREADYOUT,
    output Response_t            HRESP
);

    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam logic [ADDRWIDTH-1:0] ADDR_LIMIT = ADDRWIDTH'(4 * MEM_DEPTH);
    localparam logic [2:0] WAIT_RELOAD = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    SlvState_t            state;
    logic [2:0]           wait_cnt;
    logic [IDX_W-1:0]     idx_q;
    logic [1:0]           lo_q;
    logic [2:0]           size_q;
    logic                 write_q;
    logic                 ready_q;
    Response_t            resp_q;
    logic [DATAWIDTH-1:0] rdata_q;
    logic [DATAWIDTH-1:0] mem [MEM_DEPTH];
    logic [3:0]           strobe;
    logic                 accept;
    logic                 addr_err;
    logic                 data_read;

    assign accept = HSEL && HREADY && HTRANS[1];

    assign addr_err = (HADDR >= ADDR_LIMIT)
                   || (HSIZE > 3'd2)
                   || ((HSIZE == HALF) && HADDR[0])
                   || ((HSIZE == WORD) && (HADDR[1:0] != 2'b00));

    assign data_read = (state == S_DATA) && !write_q;

    ahb_byte_strobe u_strobe (
        .size    (size_q),
        .addr_lo (lo_q),
        .strobe  (strobe)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state    <= S_IDLE;
            wait_cnt <= 3'd0;
            idx_q    <= '0;
            lo_q     <= 2'b00;
            size_q   <= 3'd0;
            write_q  <= 1'b0;
            ready_q  <= 1'b1;
            resp_q   <= OKAY;
            rdata_q  <= '0;
        end else begin
            // Capture the word being returned so HRDATA holds it after the data phase.
            if (data_read) rdata_q <= mem[idx_q];
            case (state)
                S_WAIT: begin
                    if (wait_cnt == 3'd0) begin
                        state   <= S_DATA;
                        ready_q <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 3'd1;
                    end
                end
                S_ERR1: begin
                    state   <= S_ERR2;
                    ready_q <= 1'b1;
                    resp_q  <= ERROR;
                end
                default: begin
                    if (accept) begin
                        idx_q   <= HADDR[IDX_W+1:2];
                        lo_q    <= HADDR[1:0];
                        size_q  <= HSIZE;
                        write_q <= HWRITE;
                        if (addr_err) begin
                            state   <= S_ERR1;
                            ready_q <= 1'b0;
                            resp_q  <= ERROR;
                        end else if (WAIT_STATES > 0) begin
                            state    <= S_WAIT;
                            wait_cnt <= WAIT_RELOAD;
                            ready_q  <= 1'b0;
                            resp_q   <= OKAY;
                        end else begin
                            state   <= S_DATA;
                            ready_q <= 1'b1;
                            resp_q  <= OKAY;
                        end
                    end else begin
                        state   <= S_IDLE;
                        ready_q <= 1'b1;
                        resp_q  <= OKAY;
                    end
                end
            endcase
        end
    end

    // Writes commit only on the edge that ends a write data phase; errored writes never reach S_DATA.
    always_ff @(posedge HCLK) begin
        if (HRESETn && (state == S_DATA) && write_q) begin
            for (int i = 0; i < 4; i++) begin
                if (strobe[i]) mem[idx_q][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    assign HRDATA    = data_read ? mem[idx_q] : rdata_q;
    assign HREADYOUT = ready_q;
    assign HRESP     = resp_q;

endmodule
